// File: rtl/dbg_pkg.sv
// Shared types for the debug trigger block: FSM states, halt causes and the
// comparator count limit. The STEP state exists only when DBG_STEP_EN is defined.
package dbg_pkg;

   localparam int MAX_NUM_BP = 8;

`ifdef DBG_STEP_EN
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_REQ    = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } dbg_state_e;
`else
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_REQ    = 2'd1,
      ST_HALTED = 2'd2
   } dbg_state_e;
`endif

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_BP   = 2'd1,
      CAUSE_EXT  = 2'd2,
      CAUSE_STEP = 2'd3
   } halt_cause_e;

endpackage

// File: rtl/dbg_trigger_if.sv
// Bundle of pipeline, config and debugger signals around the debug trigger.
// The master side drives pc/config/debugger requests, the slave side is the
// trigger itself. step_mode exists only when DBG_STEP_EN is defined.
interface dbg_trigger_if
   import dbg_pkg::*;
   #(parameter int NUM_BP = 4);

   logic [63:0]       pc;
   logic              pc_valid;
   logic              cfg_we;
   logic [2:0]        cfg_idx;
   logic [63:0]       cfg_wdata;
   logic [NUM_BP-1:0] cfg_en;
   logic              dbg_halt;
   logic              dbg_resume;
   logic              halt_req;
   logic              halt_ack;
   logic              halted;
   logic [1:0]        halt_cause;
   logic [63:0]       halt_pc;
`ifdef DBG_STEP_EN
   logic              step_mode;
`endif

   modport master (
`ifdef DBG_STEP_EN
      output step_mode,
`endif
      output pc, pc_valid, cfg_we, cfg_idx, cfg_wdata, cfg_en,
      output dbg_halt, dbg_resume, halt_ack,
      input  halt_req, halted, halt_cause, halt_pc
   );

   modport slave (
`ifdef DBG_STEP_EN
      input  step_mode,
`endif
      input  pc, pc_valid, cfg_we, cfg_idx, cfg_wdata, cfg_en,
      input  dbg_halt, dbg_resume, halt_ack,
      output halt_req, halted, halt_cause, halt_pc
   );

endinterface

// File: rtl/dbg_bp_match.sv
// Breakpoint register bank and per-comparator hit vector. A hit is reported
// against the register contents before any write landing on the same edge.
module dbg_bp_match
   import dbg_pkg::*;
   #(parameter int NUM_BP = 4)
   (
      input  logic              clk,
      input  logic              rst,
      input  logic              cfg_we,
      input  logic [2:0]        cfg_idx,
      input  logic [63:0]       cfg_wdata,
      input  logic [NUM_BP-1:0] cfg_en,
      input  logic [63:0]       pc,
      output logic [NUM_BP-1:0] hit_vec
   );

   logic [63:0] bp_regs [NUM_BP];

   // Breakpoint register writes; indices past the last comparator match nothing
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BP; i++) begin
            bp_regs[i] <= '0;
         end
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (cfg_idx == 3'(i)) begin
               bp_regs[i] <= cfg_wdata;
            end
         end
      end
   end

   // Full-width compare of pc against every enabled comparator
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         hit_vec[i] = cfg_en[i] && (pc == bp_regs[i]);
      end
   end

endmodule

// File: rtl/dbg_trigger.sv
// Debug trigger: PC breakpoints and external halt requests drive a halt
// handshake with the pipeline, then wait in HALTED for a resume.
// Optional single-step support is enabled with macro DBG_STEP_EN.
module dbg_trigger
   import dbg_pkg::*;
   #(parameter int NUM_BP = 4)
   (
      input logic          clk,
      input logic          rst,
      dbg_trigger_if.slave bus
   );

   dbg_state_e        state;
   dbg_state_e        state_next;
   halt_cause_e       cause_q;
   logic [63:0]       halt_pc_q;
   logic [63:0]       last_pc;
   logic              suppress;
   logic [NUM_BP-1:0] hit_vec;
   logic              bp_hit;

   dbg_bp_match #(.NUM_BP(NUM_BP)) u_match (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (bus.cfg_we),
      .cfg_idx   (bus.cfg_idx),
      .cfg_wdata (bus.cfg_wdata),
      .cfg_en    (bus.cfg_en),
      .pc        (bus.pc),
      .hit_vec   (hit_vec)
   );

   assign bp_hit = bus.pc_valid && (state == ST_RUN) && !suppress && (|hit_vec);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: trigger, drain handshake, resume (optionally into single step)
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (bp_hit || bus.dbg_halt) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.halt_ack) begin
               state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (bus.dbg_resume) begin
`ifdef DBG_STEP_EN
               state_next = bus.step_mode ? ST_STEP : ST_RUN;
`else
               state_next = ST_RUN;
`endif
            end
         end
`ifdef DBG_STEP_EN
         ST_STEP: begin
            if (bus.pc_valid) begin
               state_next = ST_REQ;
            end
         end
`endif
         default: state_next = ST_RUN;
      endcase
   end

   // Cause/PC capture, last retired pc tracking and the post-resume suppress flag
   always_ff @(posedge clk) begin
      if (rst) begin
         cause_q   <= CAUSE_NONE;
         halt_pc_q <= '0;
         last_pc   <= '0;
         suppress  <= 1'b0;
      end else begin
         if (bus.pc_valid) begin
            last_pc <= bus.pc;
         end
         case (state)
            ST_RUN: begin
               if (bus.pc_valid) begin
                  suppress <= 1'b0;
               end
               if (bp_hit) begin
                  cause_q   <= CAUSE_BP;
                  halt_pc_q <= bus.pc;
               end else if (bus.dbg_halt) begin
                  cause_q   <= CAUSE_EXT;
                  halt_pc_q <= bus.pc_valid ? bus.pc : last_pc;
               end
            end
            ST_HALTED: begin
               if (bus.dbg_resume) begin
                  cause_q  <= CAUSE_NONE;
                  suppress <= 1'b1;
               end
            end
`ifdef DBG_STEP_EN
            ST_STEP: begin
               if (bus.pc_valid) begin
                  cause_q   <= CAUSE_STEP;
                  halt_pc_q <= bus.pc;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs are decoded from the state and the captured registers
   always_comb begin
      bus.halt_req   = (state == ST_REQ);
      bus.halted     = (state == ST_HALTED);
      bus.halt_cause = cause_q;
      bus.halt_pc    = halt_pc_q;
   end

endmodule

// File: tb/tb_dbg_trigger.sv
// Table-driven bench for dbg_trigger: each vector is driven on the falling
// edge, its expected outputs are queued, and popped/compared after the edge.
// Covers DBG_STEP_EN vectors when that macro is defined.
module tb_dbg_trigger;
   import dbg_pkg::*;

   localparam logic [63:0] BP_A = 64'h8000_0010;
   localparam logic [63:0] PC_X = 64'h8000_0020;
   localparam logic [63:0] PC_S = 64'h8000_0004;

   typedef struct {
      logic        rst;
      logic [63:0] pc;
      logic        pc_valid;
      logic        cfg_we;
      logic [2:0]  cfg_idx;
      logic [63:0] cfg_wdata;
      logic [3:0]  cfg_en;
      logic        dbg_halt;
      logic        dbg_resume;
      logic        halt_ack;
      logic        step_mode;
      logic        e_req;
      logic        e_halted;
      logic [1:0]  e_cause;
      logic [63:0] e_pc;
   } vec_t;

   typedef struct {
      logic        req;
      logic        halted;
      logic [1:0]  cause;
      logic [63:0] pc;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs[$];
   exp_t sb[$];

   dbg_trigger_if #(.NUM_BP(4)) bus ();

   dbg_trigger #(.NUM_BP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic r, input logic [63:0] p, input logic pv,
      input logic we, input logic [2:0] idx, input logic [63:0] wd, input logic [3:0] en,
      input logic hlt, input logic res, input logic ack, input logic sm,
      input logic xr, input logic xh, input logic [1:0] xc, input logic [63:0] xp);
      vec_t v;
      v.rst = r; v.pc = p; v.pc_valid = pv;
      v.cfg_we = we; v.cfg_idx = idx; v.cfg_wdata = wd; v.cfg_en = en;
      v.dbg_halt = hlt; v.dbg_resume = res; v.halt_ack = ack; v.step_mode = sm;
      v.e_req = xr; v.e_halted = xh; v.e_cause = xc; v.e_pc = xp;
      return v;
   endfunction

   task automatic cmp(input int id, input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL vec%0d %s: got %0h, expected %0h", id, name, got, want);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      rst            = v.rst;
      bus.pc         = v.pc;
      bus.pc_valid   = v.pc_valid;
      bus.cfg_we     = v.cfg_we;
      bus.cfg_idx    = v.cfg_idx;
      bus.cfg_wdata  = v.cfg_wdata;
      bus.cfg_en     = v.cfg_en;
      bus.dbg_halt   = v.dbg_halt;
      bus.dbg_resume = v.dbg_resume;
      bus.halt_ack   = v.halt_ack;
`ifdef DBG_STEP_EN
      bus.step_mode  = v.step_mode;
`endif
      e.req = v.e_req; e.halted = v.e_halted; e.cause = v.e_cause; e.pc = v.e_pc; e.id = id;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sb.pop_front();
         cmp(e.id, "halt_req",   64'(bus.halt_req),   64'(e.req));
         cmp(e.id, "halted",     64'(bus.halted),     64'(e.halted));
         cmp(e.id, "halt_cause", 64'(bus.halt_cause), 64'(e.cause));
         cmp(e.id, "halt_pc",    bus.halt_pc,         e.pc);
      end
   endtask

   task automatic runVec(input vec_t v, input int id);
      applyStimulus(v, id);
      checkOutput();
   endtask

   // Main test: vector table, then a hand-written long-REQ / reset-in-HALTED sequence
   initial begin
      int n_wait;
      rst = 1'b1;
      bus.pc = '0; bus.pc_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
      bus.cfg_wdata = '0; bus.cfg_en = '0; bus.dbg_halt = 1'b0;
      bus.dbg_resume = 1'b0; bus.halt_ack = 1'b0;
`ifdef DBG_STEP_EN
      bus.step_mode = 1'b0;
`endif

      //               rst pc            pv we idx wdata           en       hlt res ack sm   req hd cause pc
      vecs.push_back(mk(1, 64'h0,        0, 0, 0, 64'h0,         4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h0,        0, 1, 0, BP_A,          4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h0,        0, 1, 1, 64'h8000_0040, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h8000_0040,1, 0, 0, 64'h0,         4'b0001, 0, 0, 1, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, BP_A,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   1, 0, 1, BP_A));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   1, 0, 1, BP_A));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 0, 1, 0,   0, 1, 1, BP_A));
      vecs.push_back(mk(0, BP_A,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 1, 0,   0, 1, 1, BP_A));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 1, 0, 0,   0, 0, 0, BP_A));
      vecs.push_back(mk(0, BP_A,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, BP_A));
      vecs.push_back(mk(0, 64'h8000_0014,1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, BP_A));
      vecs.push_back(mk(0, BP_A,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   1, 0, 1, BP_A));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 0, 1, 0,   0, 1, 1, BP_A));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 1, 0, 0,   0, 0, 0, BP_A));
      vecs.push_back(mk(0, PC_X,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, BP_A));
      vecs.push_back(mk(0, 64'h1234_5678,0, 0, 0, 64'h0,         4'b0001, 1, 0, 0, 0,   1, 0, 2, PC_X));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 1, 0, 1, 0,   0, 1, 2, PC_X));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 1, 0, 0,   0, 0, 0, PC_X));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 1, 0, 0,   0, 0, 0, PC_X));
      vecs.push_back(mk(0, 64'h8000_0000,1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, PC_X));
      vecs.push_back(mk(0, BP_A,         1, 0, 0, 64'h0,         4'b0001, 1, 0, 0, 0,   1, 0, 1, BP_A));
      vecs.push_back(mk(1, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, BP_A,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h0,        1, 0, 0, 64'h0,         4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h0,        0, 1, 5, 64'h8000_0100, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h8000_0100,1, 0, 0, 64'h0,         4'b1111, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h8000_0200,1, 1, 2, 64'h8000_0200, 4'b0100, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h8000_0200,1, 0, 0, 64'h0,         4'b0100, 0, 0, 0, 0,   1, 0, 1, 64'h8000_0200));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0100, 0, 0, 1, 0,   0, 1, 1, 64'h8000_0200));
      vecs.push_back(mk(1, 64'h0,        0, 0, 0, 64'h0,         4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
`ifdef DBG_STEP_EN
      vecs.push_back(mk(0, 64'h0,        0, 1, 0, PC_S,          4'b0000, 1, 0, 0, 0,   1, 0, 2, 64'h0));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0000, 0, 0, 1, 0,   0, 1, 2, 64'h0));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0000, 0, 1, 0, 1,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, 64'h0));
      vecs.push_back(mk(0, PC_S,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   1, 0, 3, PC_S));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 0, 1, 0,   0, 1, 3, PC_S));
      vecs.push_back(mk(0, 64'h0,        0, 0, 0, 64'h0,         4'b0001, 0, 1, 0, 0,   0, 0, 0, PC_S));
      vecs.push_back(mk(0, PC_S,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   0, 0, 0, PC_S));
      vecs.push_back(mk(0, PC_S,         1, 0, 0, 64'h0,         4'b0001, 0, 0, 0, 0,   1, 0, 1, PC_S));
      vecs.push_back(mk(1, 64'h0,        0, 0, 0, 64'h0,         4'b0000, 0, 0, 0, 0,   0, 0, 0, 64'h0));
`endif

      $display("[TB] applying %0d table vectors", vecs.size());
      foreach (vecs[i]) begin
         runVec(vecs[i], i);
      end

      // Hand sequence: bp3 hit, halt_req held for a random number of cycles
      // without ack, then ack, then reset while HALTED
      runVec(mk(0, 64'h0, 0, 1, 3, 64'h8000_0300, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 64'h0), 100);
      runVec(mk(0, 64'h8000_0300, 1, 0, 0, 64'h0, 4'b1000, 0, 0, 0, 0, 1, 0, 1, 64'h8000_0300), 101);
      n_wait = int'($urandom_range(2, 6));
      for (int k = 0; k < n_wait; k++) begin
         runVec(mk(0, 64'h0, 0, 0, 0, 64'h0, 4'b1000, 0, 1, 0, 0, 1, 0, 1, 64'h8000_0300), 102 + k);
      end
      runVec(mk(0, 64'h0, 0, 0, 0, 64'h0, 4'b1000, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0300), 110);
      runVec(mk(0, 64'h0, 0, 0, 0, 64'h0, 4'b1000, 0, 0, 0, 0, 0, 1, 1, 64'h8000_0300), 111);
      runVec(mk(1, 64'h0, 0, 0, 0, 64'h0, 4'b1000, 0, 1, 0, 0, 0, 0, 0, 64'h0), 112);
      runVec(mk(0, 64'h8000_0300, 1, 0, 0, 64'h0, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 64'h0), 113);

      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL scoreboard drain: got %0d leftover, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no completion, expected finish before limit");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/dbg_trigger.md
DBG_TRIGGER -- requirements
Module: dbg_trigger

Interface
REQ-001 SHALL have parameter NUM_BP, default 4, giving the number of PC breakpoint comparators (legal range 1..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port pc  input  64  PC of the instruction currently in execute.
REQ-005 SHALL have port pc_valid  input  1  pc holds a retiring instruction this cycle.
REQ-006 SHALL have ports cfg_we (input, 1), cfg_idx (input, 3) and cfg_wdata (input, 64), which form the breakpoint register write port.
REQ-007 SHALL have port cfg_en  input  NUM_BP  per-comparator enable mask.
REQ-008 SHALL have port dbg_halt  input  1  external debugger halt request (level).
REQ-009 SHALL have port dbg_resume  input  1  one-cycle resume pulse.
REQ-010 SHALL have port halt_req  output  1  request to the pipeline, consumed as an ebreak-class system operation.
REQ-011 SHALL have port halt_ack  input  1  pipeline confirms it has drained and stopped.
REQ-012 SHALL have port halted  output  1  core is in debug halt.
REQ-013 SHALL have port halt_cause  output  2  encoding: 0 none, 1 breakpoint, 2 external halt, 3 single step.
REQ-014 SHALL have port halt_pc  output  64  PC captured at the trigger.

Function
REQ-015 SHALL hold NUM_BP 64-bit breakpoint registers; a write with cfg_we=1 stores cfg_wdata into register cfg_idx on the next edge, and a write with cfg_idx>=NUM_BP is ignored.
REQ-016 SHALL declare a breakpoint hit when pc_valid=1, the state is RUN, and pc equals any enabled register (full 64-bit compare).
REQ-017 SHALL implement FSM states RUN, REQ, HALTED and STEP.
REQ-018 SHALL use these RUN transitions:
- hit -> REQ with cause=1;
- otherwise dbg_halt=1 -> REQ with cause=2;
- a hit takes priority when both occur in the same cycle.
REQ-019 SHALL capture halt_pc on the RUN->REQ edge: pc for a breakpoint, or the last valid pc for an external halt.
REQ-020 SHALL assert halt_req in REQ, held until halt_ack=1, then go to HALTED the next cycle.
REQ-021 SHALL ignore halt_ack outside REQ.
REQ-022 SHALL assert halted=1 exactly in HALTED, with halt_cause and halt_pc stable there.
REQ-023 SHALL, in HALTED, on dbg_resume=1 go to RUN, clear halt_cause to 0, and suppress a breakpoint hit on the first pc_valid after resume (no re-trigger at the same PC).
REQ-024 SHALL ignore dbg_resume outside HALTED.
REQ-025 SHALL apply the cfg write in a cycle where it coincides with a hit, but evaluate the hit against the pre-write value.
REQ-026 SHALL be such that halt_req rises one cycle after the triggering pc_valid, and halted rises one cycle after halt_ack.

Reset
REQ-027 SHALL, on rst=1, set state=RUN, halt_req=0, halted=0, halt_cause=0, halt_pc=0, all breakpoint registers=0 and the resume-suppress flag=0.
REQ-028 SHALL have reset take priority over every other event, including mid-REQ and mid-HALTED, and SHALL drop halt_req in the cycle after reset is sampled.

Configuration
REQ-029 SHALL, with macro DBG_STEP_EN defined, add input step_mode (1 bit); when dbg_resume is seen with step_mode=1, go HALTED->STEP.
REQ-030 SHALL, in STEP, on the first pc_valid, capture pc and go to REQ with cause=3, while breakpoint matching stays suppressed for that instruction.
REQ-031 SHALL, without DBG_STEP_EN, have no step_mode port and no STEP state, and cause 3 is never produced.

Structure
REQ-032 SHALL place the FSM state enum, the halt_cause enum and the NUM_BP maximum constant in shared package dbg_pkg.
REQ-033 SHALL implement the comparator bank as sub-module dbg_bp_match (registers plus hit vector), with the FSM in dbg_trigger.

Verification
REQ-034 SHALL cover: bp0=0x80000010, cfg_en=0001, pc_valid with pc=0x80000010 -> halt_req the next cycle; halt_ack -> halted=1, cause=1, halt_pc=0x80000010.
REQ-035 SHALL cover: dbg_halt=1 while pc=0x80000020 is the last valid pc, no hit -> cause=2, halt_pc=0x80000020.
REQ-036 SHALL cover: a hit and dbg_halt=1 in the same cycle -> cause=1.
REQ-037 SHALL cover: a resume from a breakpoint at 0x80000010 with the same pc next -> no re-halt; a later pc=0x80000010 -> halt.
REQ-038 SHALL cover: rst=1 while in REQ -> halt_req=0, halted=0, cause=0 next cycle, and bp0 reads as no-match at pc=0.
REQ-039 SHALL cover (DBG_STEP_EN): step_mode=1 plus resume, then pc=0x80000004 -> cause=3, halt_pc=0x80000004.
